// File: rtl/pfs_sector_link.sv
// pfs_sector_link: framed serial link core for a daughtercard sector.
// TX FIFO feeds a serializer; RX deframer feeds an FWFT FIFO.

module pfs_sector_link_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // a pop frees the slot, so a push into a full FIFO still lands
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clr_i) mem_q[wr_q] <= din_i;
  end
endmodule

module pfs_sector_link #(
  parameter int DATA_W      = 34,
  parameter int DEPTH       = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int IDLE_GAP    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_clr,
  input  logic [DATA_W-1:0] tx_din,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_ovf,
  output logic              sout,
  input  logic              sin,
  output logic [DATA_W-1:0] rx_dout,
  input  logic              rx_rd,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              rx_err,
  output logic [31:0]       tx_count,
  output logic [31:0]       rx_count,
  output logic [31:0]       parity_fail_cnt,
  output logic [31:0]       stopbit_fail_cnt,
  output logic [31:0]       rx_ovf_cnt
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY_MODE != 0);
  localparam logic ODD     = (PARITY_MODE == 2);
  localparam logic [7:0] GAP_INIT =
    (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP, T_GAP
  } tx_st_e;

  typedef enum logic [2:0] {
    R_IDLE, R_DATA, R_PAR, R_STOP, R_RESYNC
  } rx_st_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---------------- TX path ----------------
  logic [DATA_W-1:0] txf_dout;
  logic              txf_full;
  logic              txf_empty;
  logic              tx_pop;

  pfs_sector_link_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_txf (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (soft_clr),
    .push_i  (tx_wr),
    .pop_i   (tx_pop),
    .din_i   (tx_din),
    .dout_o  (txf_dout),
    .full_o  (txf_full),
    .empty_o (txf_empty)
  );

  tx_st_e            tst_q, tst_d;
  logic              sout_q, sout_d;
  logic [DATA_W-1:0] tsh_q, tsh_d;
  logic              tpar_q, tpar_d;
  logic [BW-1:0]     tbit_q, tbit_d;
  logic [7:0]        tgap_q, tgap_d;
  logic              tdone_q, tdone_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic [31:0]       tx_cnt_q, tx_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tst_q <= T_IDLE;
    else       tst_q <= tst_d;
  end

  always_comb begin
    tst_d  = tst_q;
    tx_pop = 1'b0;
    unique case (tst_q)
      T_IDLE: begin
        if (!txf_empty) begin
          tst_d  = T_START;
          tx_pop = 1'b1;
        end
      end
      T_START: tst_d = T_DATA;
      T_DATA: begin
        if (tbit_q == LAST_BIT) tst_d = HAS_PAR ? T_PAR : T_STOP;
      end
      T_PAR: tst_d = T_STOP;
      T_STOP: begin
        // with no gap, the next start bit follows the last stop bit
        if (tbit_q == LAST_STOP) begin
          if (IDLE_GAP > 0) tst_d = T_GAP;
          else if (!txf_empty) begin
            tst_d  = T_START;
            tx_pop = 1'b1;
          end else tst_d = T_IDLE;
        end
      end
      T_GAP: begin
        if (tgap_q == '0) begin
          if (!txf_empty) begin
            tst_d  = T_START;
            tx_pop = 1'b1;
          end else tst_d = T_IDLE;
        end
      end
      default: tst_d = T_IDLE;
    endcase
    if (soft_clr) tst_d = T_IDLE;
  end

  always_comb begin
    sout_d   = sout_q;
    tsh_d    = tsh_q;
    tpar_d   = tpar_q;
    tbit_d   = tbit_q;
    tgap_d   = tgap_q;
    tdone_d  = 1'b0;
    if (tx_pop) begin
      tsh_d  = txf_dout;
      tpar_d = (^txf_dout) ^ ODD;
    end
    unique case (tst_q)
      T_IDLE:  sout_d = 1'b1;
      T_START: begin
        sout_d = 1'b0;
        tbit_d = '0;
      end
      T_DATA: begin
        sout_d = tsh_q[0];
        tsh_d  = tsh_q >> 1;
        tbit_d = (tbit_q == LAST_BIT) ? '0 : tbit_q + BW'(1);
      end
      T_PAR: begin
        sout_d = tpar_q;
        tbit_d = '0;
      end
      T_STOP: begin
        sout_d = 1'b1;
        if (tbit_q == LAST_STOP) begin
          tbit_d  = '0;
          tdone_d = 1'b1;
          tgap_d  = GAP_INIT;
        end else tbit_d = tbit_q + BW'(1);
      end
      T_GAP: begin
        sout_d = 1'b1;
        if (tgap_q != '0) tgap_d = tgap_q - 8'd1;
      end
      default: sout_d = 1'b1;
    endcase
    tx_ovf_d = tx_ovf_q | (tx_wr && txf_full && !tx_pop);
    tx_cnt_d = tdone_q ? sat_inc(tx_cnt_q) : tx_cnt_q;
    if (soft_clr) begin
      sout_d   = 1'b1;
      tsh_d    = '0;
      tpar_d   = 1'b0;
      tbit_d   = '0;
      tgap_d   = '0;
      tdone_d  = 1'b0;
      tx_ovf_d = 1'b0;
      tx_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sout_q   <= 1'b1;
      tsh_q    <= '0;
      tpar_q   <= 1'b0;
      tbit_q   <= '0;
      tgap_q   <= '0;
      tdone_q  <= 1'b0;
      tx_ovf_q <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      sout_q   <= sout_d;
      tsh_q    <= tsh_d;
      tpar_q   <= tpar_d;
      tbit_q   <= tbit_d;
      tgap_q   <= tgap_d;
      tdone_q  <= tdone_d;
      tx_ovf_q <= tx_ovf_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign sout     = sout_q;
  assign tx_full  = txf_full;
  assign tx_ovf   = tx_ovf_q;
  assign tx_count = tx_cnt_q;
  assign tx_empty = txf_empty && (tst_q == T_IDLE) && !tdone_q;

  // ---------------- RX path ----------------
  rx_st_e            rst_q, rst_d;
  logic              s1_q, s2_q;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic [BW-1:0]     rbit_q, rbit_d;
  logic              rpbad_q, rpbad_d;
  logic              rwr_q, rwr_d;
  logic              par_hit;
  logic              stop_hit;
  logic              ovf_hit;
  logic              rx_err_q, rx_err_d;
  logic [31:0]       rx_cnt_q, rx_cnt_d;
  logic [31:0]       pf_cnt_q, pf_cnt_d;
  logic [31:0]       sf_cnt_q, sf_cnt_d;
  logic [31:0]       ro_cnt_q, ro_cnt_d;
  logic              rxf_full;
  logic              rxf_empty;

  pfs_sector_link_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rxf (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (soft_clr),
    .push_i  (rwr_q),
    .pop_i   (rx_rd),
    .din_i   (rsh_q),
    .dout_o  (rx_dout),
    .full_o  (rxf_full),
    .empty_o (rxf_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else if (soft_clr) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= sin;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_q <= R_IDLE;
    else       rst_q <= rst_d;
  end

  always_comb begin
    rst_d = rst_q;
    unique case (rst_q)
      R_IDLE: if (!s2_q) rst_d = R_DATA;
      R_DATA: begin
        if (rbit_q == LAST_BIT) rst_d = HAS_PAR ? R_PAR : R_STOP;
      end
      R_PAR: rst_d = R_STOP;
      R_STOP: begin
        if (!s2_q) rst_d = R_RESYNC;
        else if (rbit_q == LAST_STOP) rst_d = R_IDLE;
      end
      R_RESYNC: if (s2_q) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
    if (soft_clr) rst_d = R_IDLE;
  end

  always_comb begin
    rsh_d    = rsh_q;
    rbit_d   = rbit_q;
    rpbad_d  = rpbad_q;
    rwr_d    = 1'b0;
    par_hit  = 1'b0;
    stop_hit = 1'b0;
    unique case (rst_q)
      R_IDLE: begin
        rbit_d  = '0;
        rpbad_d = 1'b0;
      end
      R_DATA: begin
        rsh_d  = {s2_q, rsh_q[DATA_W-1:1]};
        rbit_d = (rbit_q == LAST_BIT) ? '0 : rbit_q + BW'(1);
      end
      R_PAR: begin
        par_hit = (s2_q != ((^rsh_q) ^ ODD));
        rpbad_d = par_hit;
        rbit_d  = '0;
      end
      R_STOP: begin
        if (!s2_q) stop_hit = 1'b1;
        else if (rbit_q == LAST_STOP) rwr_d = !rpbad_q;
        else rbit_d = rbit_q + BW'(1);
      end
      default: rbit_d = '0;
    endcase
    ovf_hit  = rwr_q && rxf_full && !rx_rd;
    rx_err_d = rx_err_q | par_hit | stop_hit | ovf_hit;
    rx_cnt_d = (rwr_q && !ovf_hit) ? sat_inc(rx_cnt_q) : rx_cnt_q;
    pf_cnt_d = par_hit ? sat_inc(pf_cnt_q) : pf_cnt_q;
    sf_cnt_d = stop_hit ? sat_inc(sf_cnt_q) : sf_cnt_q;
    ro_cnt_d = ovf_hit ? sat_inc(ro_cnt_q) : ro_cnt_q;
    if (soft_clr) begin
      rsh_d    = '0;
      rbit_d   = '0;
      rpbad_d  = 1'b0;
      rwr_d    = 1'b0;
      rx_err_d = 1'b0;
      rx_cnt_d = '0;
      pf_cnt_d = '0;
      sf_cnt_d = '0;
      ro_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsh_q    <= '0;
      rbit_q   <= '0;
      rpbad_q  <= 1'b0;
      rwr_q    <= 1'b0;
      rx_err_q <= 1'b0;
      rx_cnt_q <= '0;
      pf_cnt_q <= '0;
      sf_cnt_q <= '0;
      ro_cnt_q <= '0;
    end else begin
      rsh_q    <= rsh_d;
      rbit_q   <= rbit_d;
      rpbad_q  <= rpbad_d;
      rwr_q    <= rwr_d;
      rx_err_q <= rx_err_d;
      rx_cnt_q <= rx_cnt_d;
      pf_cnt_q <= pf_cnt_d;
      sf_cnt_q <= sf_cnt_d;
      ro_cnt_q <= ro_cnt_d;
    end
  end

  assign rx_empty         = rxf_empty;
  assign rx_full          = rxf_full;
  assign rx_err           = rx_err_q;
  assign rx_count         = rx_cnt_q;
  assign parity_fail_cnt  = pf_cnt_q;
  assign stopbit_fail_cnt = sf_cnt_q;
  assign rx_ovf_cnt       = ro_cnt_q;
endmodule
